mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide controller in the EX stage, next to the ALU. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO, owns the HI/LO registers, and models a fixed operation latency with a busy counter. It produces the stall request the hazard unit uses to hold a dependent MDU instruction in D while an operation is in flight.

---
 rtl/mdu_ctrl.sv | 154 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, models a fixed MULT/DIV latency with a busy counter.
// Latency: MULT/MULTU commit MULT_CYCLES edges after start, DIV/DIVU DIV_CYCLES edges after; MTHI/MTLO take effect at once.
// Backpressure: stall is raised combinationally for MDU users in D while start is asserted or an operation is in flight.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     hi_n_q, hi_n_d;
    logic [31:0]     lo_n_q, lo_n_d;
    logic            dz_q, dz_d;

    // Arithmetic results for the operation presented with start
    logic [63:0]     prod_s, prod_u;
    logic            a_neg, b_neg, b_zero;
    logic [31:0]     a_mag, b_mag, b_safe, b_mag_safe;
    logic [31:0]     uq_s, ur_s, q_s, r_s, q_u, r_u;
    logic [31:0]     res_hi, res_lo;
    logic            res_dz;

    // Compute product/quotient/remainder for the current operands; division uses
    // magnitudes so the most-negative / -1 case wraps cleanly instead of overflowing.
    always_comb begin
        prod_s     = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u     = {32'd0, A} * {32'd0, B};
        a_neg      = A[31];
        b_neg      = B[31];
        b_zero     = (B == 32'd0);
        a_mag      = a_neg ? (32'd0 - A) : A;
        b_mag      = b_neg ? (32'd0 - B) : B;
        b_safe     = b_zero ? 32'd1 : B;
        b_mag_safe = b_zero ? 32'd1 : b_mag;
        uq_s       = a_mag / b_mag_safe;
        ur_s       = a_mag % b_mag_safe;
        q_s        = (a_neg ^ b_neg) ? (32'd0 - uq_s) : uq_s;
        r_s        = a_neg ? (32'd0 - ur_s) : ur_s;
        q_u        = A / b_safe;
        r_u        = A % b_safe;
        res_hi     = 32'd0;
        res_lo     = 32'd0;
        res_dz     = 1'b0;
        case (md_op)
            2'd0: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            2'd1: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            2'd2: begin
                res_hi = r_s;
                res_lo = q_s;
                res_dz = b_zero;
            end
            default: begin
                res_hi = r_u;
                res_lo = q_u;
                res_dz = b_zero;
            end
        endcase
    end

    // Next-state: launch ops from IDLE, count down in RUN, commit shadow result on the last edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    hi_n_d  = res_hi;
                    lo_n_d  = res_lo;
                    dz_d    = res_dz;
                    cnt_d   = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_d = RUN;
                end else if (hilo_we) begin
                    if (hilo_sel) begin
                        hi_d = A;
                    end else begin
                        lo_d = A;
                    end
                end
            end
            default: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (!dz_q) begin
                        hi_d = hi_n_q;
                        lo_d = lo_n_q;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_n_q  <= 32'd0;
            lo_n_q  <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
            dz_q    <= dz_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign stall = md_use & (start | busy);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed vector table, hand-written corner sequences, random traffic.
// Latency: checks exact MULT/DIV busy durations against the reference model.
// Backpressure: stall is compared every cycle against md_use & (start | busy).
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] A, B;
    logic        hilo_we, hilo_sel, md_use;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pv;
    int          m_rem;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .A        (A),
        .B        (B),
        .hilo_we  (hilo_we),
        .hilo_sel (hilo_sel),
        .md_use   (md_use),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        is_mt;
        logic [1:0]  op;
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Behavioural model step for one rising edge using the inputs currently applied
    task automatic model_edge();
        logic [63:0] p;
        longint      sa, sb, q, r;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_rem = 0; m_pv = 0; m_phi = 0; m_plo = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pv) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start) begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            m_pv = 1'b1;
            case (md_op)
                2'd0: begin p = 64'(sa * sb); m_phi = p[63:32]; m_plo = p[31:0]; end
                2'd1: begin p = {32'd0, A} * {32'd0, B}; m_phi = p[63:32]; m_plo = p[31:0]; end
                2'd2: begin
                    if (B == 0) m_pv = 1'b0;
                    else begin
                        q = sa / sb; r = sa % sb;
                        m_phi = r[31:0]; m_plo = q[31:0];
                    end
                end
                default: begin
                    if (B == 0) m_pv = 1'b0;
                    else begin m_phi = A % B; m_plo = A / B; end
                end
            endcase
            m_rem = md_op[1] ? DC : MC;
        end else if (hilo_we) begin
            if (hilo_sel) m_hi = A;
            else m_lo = A;
        end
    endtask

    // One clock cycle: check stall before the edge, advance the model, check registered outputs after
    task automatic cyc();
        #1;
        chk("stall", {31'd0, stall}, {31'd0, md_use & (start | (m_rem > 0))});
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    task automatic idle_inputs();
        start = 0; hilo_we = 0; hilo_sel = 0; md_op = 0; A = 0; B = 0; md_use = 0; reset = 0;
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1;
        m_hi = 0; m_lo = 0; m_rem = 0; m_pv = 0; m_phi = 0; m_plo = 0;
        repeat (2) @(posedge clk);
        #1;
        cyc();
        reset = 0;

        // reset state, idle with md_use toggling
        for (int i = 0; i < 3; i++) begin
            md_use = i[0];
            cyc();
        end
        md_use = 1;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        md_use = 0;

        tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'hFFFFFFFE, 32'd3,        MC, 32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1]  = '{1'b0, 2'd1, 1'b0, 32'hFFFFFFFE, 32'd3,        MC, 32'h00000002, 32'hFFFFFFFA};
        tbl[2]  = '{1'b0, 2'd2, 1'b0, 32'hFFFFFFF9, 32'd2,        DC, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{1'b0, 2'd3, 1'b0, 32'd7,        32'd2,        DC, 32'h00000001, 32'h00000003};
        tbl[4]  = '{1'b1, 2'd0, 1'b1, 32'h1234,     32'd0,        0,  32'h00001234, 32'h00000003};
        tbl[5]  = '{1'b1, 2'd0, 1'b0, 32'h5678,     32'd0,        0,  32'h00001234, 32'h00005678};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'd99,       32'd0,        DC, 32'h00001234, 32'h00005678};
        tbl[7]  = '{1'b0, 2'd3, 1'b0, 32'd99,       32'd0,        DC, 32'h00001234, 32'h00005678};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h80000000, 32'hFFFFFFFF, DC, 32'h00000000, 32'h80000000};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 32'h80000000, 32'h80000000, MC, 32'h40000000, 32'h00000000};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'd7,        32'hFFFFFFFE, DC, 32'h00000001, 32'hFFFFFFFD};

        for (int i = 0; i < 11; i++) begin
            A = tbl[i].a; B = tbl[i].b; md_op = tbl[i].op; hilo_sel = tbl[i].sel;
            start = !tbl[i].is_mt; hilo_we = tbl[i].is_mt;
            cyc();
            idle_inputs();
            n = 0;
            while (busy && n < 50) begin
                cyc();
                n++;
            end
            chk($sformatf("vec%0d_lat", i), n, tbl[i].lat);
            chk($sformatf("vec%0d_hi", i), hi, tbl[i].ehi);
            chk($sformatf("vec%0d_lo", i), lo, tbl[i].elo);
        end

        // pulses of hilo_we and start during a MULT are ignored, stall held high
        A = 5; B = 7; md_op = 2'd0; start = 1; md_use = 1;
        #1;
        chk("ovl_stall_start", {31'd0, stall}, 32'd1);
        cyc();
        start = 0;
        for (int i = 0; i < MC; i++) begin
            hilo_we = (i == 1); hilo_sel = 0; A = (i == 1) ? 32'hAAAA : 32'd9;
            start = (i == 2); md_op = 2'd3; B = 32'd3;
            #1;
            chk("ovl_stall", {31'd0, stall}, 32'd1);
            cyc();
        end
        idle_inputs();
        chk("ovl_busy", {31'd0, busy}, 32'd0);
        chk("ovl_hi", hi, 32'd0);
        chk("ovl_lo", lo, 32'd35);

        // start and hilo_we together: start wins
        A = 32'd6; B = 32'd4; md_op = 2'd1; start = 1; hilo_we = 1; hilo_sel = 1;
        cyc();
        idle_inputs();
        repeat (MC) cyc();
        chk("both_hi", hi, 32'd0);
        chk("both_lo", lo, 32'd24);

        // reset in cycle 4 of a DIV aborts it with no later commit
        A = 32'h11; hilo_we = 1; hilo_sel = 1; cyc();
        A = 32'h22; hilo_sel = 0; cyc();
        idle_inputs();
        A = 32'd100; B = 32'd3; md_op = 2'd2; start = 1;
        cyc();
        idle_inputs();
        repeat (3) cyc();
        reset = 1;
        cyc();
        reset = 0;
        chk("rabort_busy", {31'd0, busy}, 32'd0);
        chk("rabort_hi", hi, 32'd0);
        chk("rabort_lo", lo, 32'd0);
        repeat (15) cyc();
        chk("rabort_late_hi", hi, 32'd0);
        chk("rabort_late_lo", lo, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 5) == 0);
            md_op    = 2'($urandom_range(0, 3));
            A        = $urandom;
            B        = ($urandom_range(0, 7) == 0) ? 32'd0 :
                       (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            hilo_we  = ($urandom_range(0, 3) == 0);
            hilo_sel = 1'($urandom_range(0, 1));
            md_use   = 1'($urandom_range(0, 1));
            reset    = ($urandom_range(0, 99) == 0);
            cyc();
        end
        idle_inputs();
        repeat (DC + 2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
